// File: rtl/pattern_sequencer_pkg.sv
// Shared types and constants for the 240p suite pattern sequencer.
package pattern_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    COMMIT,
    HOLD
  } seq_state_t;

  localparam int unsigned DEF_NUM_PATTERNS = 12;
  localparam int unsigned FRAME_CNT_W      = 16;

  localparam int unsigned PAT_BORDER    = 0;
  localparam int unsigned PAT_COLORBARS = 1;
  localparam int unsigned PAT_GRID      = 2;
  localparam int unsigned PAT_MONOSCOPE = 3;

endpackage

// File: rtl/pattern_sequencer_if.sv
// Pattern-sequencer signal bundle: slave = sequencer, master = driver/observer.
interface pattern_sequencer_if
  import pattern_sequencer_pkg::*;
#(
  parameter int unsigned SEL_W = 4
) ();

  logic                   vblank;
  logic                   btn_next;
  logic                   btn_prev;
  logic                   auto_en;
  logic [SEL_W-1:0]       pattern_sel;
  logic                   pattern_stb;
  logic [FRAME_CNT_W-1:0] frame_cnt;
  logic                   busy;

  modport master (
    output vblank, btn_next, btn_prev, auto_en,
    input  pattern_sel, pattern_stb, frame_cnt, busy
  );

  modport slave (
    input  vblank, btn_next, btn_prev, auto_en,
    output pattern_sel, pattern_stb, frame_cnt, busy
  );

endinterface

// File: rtl/pattern_sequencer_btn_sync.sv
// Raw button synchroniser: two flops, then a registered rising-edge pulse (3 clk latency).
module suite_btn_sync (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic [2:0] sr;

  always_ff @(posedge clk) begin
    if (reset) begin
      sr    <= '0;
      pulse <= 1'b0;
    end else begin
      sr    <= {sr[1:0], btn};
      pulse <= sr[1] & ~sr[2];
    end
  end

endmodule

// File: rtl/pattern_sequencer.sv
// Test-pattern selector: button changes committed only at vblank rising edge.
// Optional auto-cycle mode enabled with `define SUITE_AUTOCYCLE_EN.
module pattern_sequencer
  import pattern_sequencer_pkg::*;
#(
  parameter int unsigned NUM_PATTERNS = DEF_NUM_PATTERNS,
  parameter int unsigned SEL_W        = 4,
  parameter int unsigned HOLD_FRAMES  = 8,
  parameter int unsigned AUTO_FRAMES  = 300
) (
  input logic               clk,
  input logic               reset,
  pattern_sequencer_if.slave bus
);

  localparam int unsigned HOLD_W = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_FRAMES);
  localparam logic [SEL_W-1:0]  SEL_MAX   = SEL_W'(NUM_PATTERNS - 1);

  seq_state_t             state, state_d;
  logic                   dir_up, dir_d;
  logic [HOLD_W-1:0]      hold_cnt, hold_d;
  logic                   vblank_q;
  logic                   tick;
  logic                   next_ev, prev_ev;
  logic                   auto_req;
  logic [SEL_W-1:0]       sel_q, sel_step;
  logic                   stb_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_q;

  suite_btn_sync u_sync_next (.clk(clk), .reset(reset), .btn(bus.btn_next), .pulse(next_ev));
  suite_btn_sync u_sync_prev (.clk(clk), .reset(reset), .btn(bus.btn_prev), .pulse(prev_ev));

  assign tick = bus.vblank & ~vblank_q;

`ifdef SUITE_AUTOCYCLE_EN
  assign auto_req = bus.auto_en && (frame_cnt_q >= FRAME_CNT_W'(AUTO_FRAMES));
`else
  localparam int unsigned auto_frames_unused = AUTO_FRAMES;
  logic auto_en_unused;
  assign auto_en_unused = bus.auto_en;
  assign auto_req       = 1'b0;
`endif

  // Explicit compare-and-wrap keeps pattern_sel inside 0..NUM_PATTERNS-1.
  always_comb begin
    sel_step = sel_q;
    if (dir_up) sel_step = (sel_q == SEL_MAX) ? '0 : sel_q + 1'b1;
    else        sel_step = (sel_q == '0) ? SEL_MAX : sel_q - 1'b1;
  end

  always_comb begin
    state_d = state;
    dir_d   = dir_up;
    hold_d  = hold_cnt;
    case (state)
      IDLE: begin
        if (next_ev ^ prev_ev) begin
          state_d = ARMED;
          dir_d   = next_ev;
        end else if (!next_ev && !prev_ev && auto_req) begin
          state_d = ARMED;
          dir_d   = 1'b1;
        end
      end
      ARMED: begin
        if (tick) state_d = COMMIT;
      end
      COMMIT: begin
        hold_d  = HOLD_INIT;
        state_d = (HOLD_FRAMES == 0) ? IDLE : HOLD;
      end
      HOLD: begin
        if (hold_cnt == '0) state_d = IDLE;
        else if (tick)      hold_d  = hold_cnt - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      dir_up      <= 1'b0;
      hold_cnt    <= '0;
      vblank_q    <= 1'b0;
      sel_q       <= '0;
      stb_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state    <= state_d;
      dir_up   <= dir_d;
      hold_cnt <= hold_d;
      vblank_q <= bus.vblank;
      stb_q    <= (state == COMMIT);
      if (state == COMMIT) begin
        sel_q       <= sel_step;
        frame_cnt_q <= '0;
      end else if (tick && (frame_cnt_q != '1)) begin
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end
    end
  end

  assign bus.pattern_sel = sel_q;
  assign bus.pattern_stb = stb_q;
  assign bus.frame_cnt   = frame_cnt_q;
  assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed self-checking bench for pattern_sequencer (default and SUITE_AUTOCYCLE_EN builds).
module tb_pattern_sequencer;
  import pattern_sequencer_pkg::*;

  localparam int unsigned NP = 12;
`ifdef SUITE_AUTOCYCLE_EN
  localparam int unsigned HF = 0;
  localparam int unsigned AF = 5;
`else
  localparam int unsigned HF = 8;
  localparam int unsigned AF = 300;
`endif
  localparam int FRAME_CLKS = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pattern_sequencer_if #(.SEL_W(4)) bus ();

  pattern_sequencer #(
    .NUM_PATTERNS(NP),
    .SEL_W(4),
    .HOLD_FRAMES(HF),
    .AUTO_FRAMES(AF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int stb_count = 0;
  int stb_cyc = 0;
  int rise_cyc = 0;
  int base;
  int first_cyc;
  logic [3:0]  stb_sel = '0;
  logic [15:0] stb_fc = '0;
  logic        sel_bad = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.pattern_stb === 1'b1) begin
      stb_count++;
      stb_cyc = cyc;
      stb_sel = bus.pattern_sel;
      stb_fc  = bus.frame_cnt;
    end
    if (!reset && !(bus.pattern_sel < 4'(NP))) sel_bad = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame();
    bus.vblank = 1'b1;
    rise_cyc   = cyc;
    step(3);
    bus.vblank = 1'b0;
    step(FRAME_CLKS - 3);
  endtask

  task automatic press(input logic nxt, input logic prv);
    bus.btn_next = nxt;
    bus.btn_prev = prv;
    step(2);
    bus.btn_next = 1'b0;
    bus.btn_prev = 1'b0;
    step(3);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    step(1);
  endtask

  initial begin
    bus.vblank   = 1'b0;
    bus.btn_next = 1'b0;
    bus.btn_prev = 1'b0;
    bus.auto_en  = 1'b0;
    reset        = 1'b1;
    do_reset();

    check("rst_sel",  32'(bus.pattern_sel), 0);
    check("rst_stb",  32'(bus.pattern_stb), 0);
    check("rst_fcnt", 32'(bus.frame_cnt),   0);
    check("rst_busy", 32'(bus.busy),        0);

    // Idle frames; auto_en must be inert in the default build.
`ifdef SUITE_AUTOCYCLE_EN
    bus.auto_en = 1'b0;
`else
    bus.auto_en = 1'b1;
`endif
    repeat (3) frame();
    check("idle_fcnt", 32'(bus.frame_cnt), 3);
    check("idle_sel",  32'(bus.pattern_sel), 0);
    check("idle_stb",  32'(stb_count), 0);
    bus.auto_en = 1'b0;

    // Next press: commit 2 clk after vblank rise.
    press(1'b1, 1'b0);
    check("armed_busy", 32'(bus.busy), 1);
    base = stb_count;
    frame();
    check("next_stb_cnt", 32'(stb_count - base), 1);
    check("next_sel",     32'(stb_sel), 1);
    check("next_fcnt",    32'(stb_fc), 0);
    check("next_latency", 32'(stb_cyc - rise_cyc), 2);
    repeat (HF) frame();
    step(2);
    check("hold_done_busy", 32'(bus.busy), 0);
    check("hold_done_fcnt", 32'(bus.frame_cnt), HF);

    // Wrap-around in both directions.
    press(1'b1, 1'b0); frame(); repeat (HF) frame();
    press(1'b0, 1'b1); frame();
    check("prev_sel", 32'(stb_sel), 1);
    repeat (HF) frame();
    step(1);
    base = stb_count;
    // drive to 0 then wrap down
    press(1'b0, 1'b1); frame(); repeat (HF) frame();
    press(1'b0, 1'b1); frame();
    check("wrap_down_sel", 32'(stb_sel), NP - 1);
    repeat (HF) frame();
    press(1'b1, 1'b0); frame();
    check("wrap_up_sel", 32'(stb_sel), 0);
    check("wrap_stb_cnt", 32'(stb_count - base), 3);
    repeat (HF) frame();
    step(2);

    // Simultaneous next+prev cancels.
    base = stb_count;
    press(1'b1, 1'b1);
    check("cancel_busy", 32'(bus.busy), 0);
    frame();
    check("cancel_stb", 32'(stb_count - base), 0);
    check("cancel_sel", 32'(bus.pattern_sel), 0);

`ifndef SUITE_AUTOCYCLE_EN
    // Press during HOLD (4th frame of 8) is ignored.
    press(1'b1, 1'b0);
    frame();
    check("pre_hold_sel", 32'(bus.pattern_sel), 1);
    base = stb_count;
    repeat (3) frame();
    check("in_hold_busy", 32'(bus.busy), 1);
    press(1'b1, 1'b0);
    repeat (7) frame();
    check("hold_press_sel", 32'(bus.pattern_sel), 1);
    check("hold_press_stb", 32'(stb_count - base), 0);
    check("hold_press_busy", 32'(bus.busy), 0);
`endif

    // Reset while ARMED discards the request.
    press(1'b1, 1'b0);
    check("arm_busy", 32'(bus.busy), 1);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(1);
    check("armrst_busy", 32'(bus.busy), 0);
    base = stb_count;
    frame();
    check("armrst_stb",  32'(stb_count - base), 0);
    check("armrst_sel",  32'(bus.pattern_sel), 0);
    check("armrst_busy2", 32'(bus.busy), 0);

`ifdef SUITE_AUTOCYCLE_EN
    // Auto-cycle: one advance every AF+1 frames with HOLD_FRAMES=0.
    do_reset();
    bus.auto_en = 1'b0;
    base = stb_count;
    repeat (8) frame();
    check("auto_off_sel", 32'(bus.pattern_sel), 0);
    check("auto_off_stb", 32'(stb_count - base), 0);
    bus.auto_en = 1'b1;
    frame();
    check("auto_first_sel", 32'(bus.pattern_sel), 1);
    first_cyc = stb_cyc;
    repeat (12) frame();
    check("auto_stb_cnt", 32'(stb_count - base), 3);
    check("auto_sel",     32'(bus.pattern_sel), 3);
    check("auto_period",  32'(stb_cyc - first_cyc), 2 * (AF + 1) * FRAME_CLKS);
    bus.auto_en = 1'b0;
    repeat (8) frame();
    check("auto_stop_sel", 32'(bus.pattern_sel), 3);
`endif

    check("sel_in_range", 32'(sel_bad), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
